// File: rtl/block_dispatcher.sv
// Block dispatcher: splits a kernel of thread_count threads into blocks of up to
// THREADS_PER_BLOCK threads and hands them out, one per cycle, to idle cores.
// Ports:
//   clk, reset           - rising-edge clock, synchronous active-high reset
//   start                - level-sensitive kernel launch request
//   thread_count[7:0]    - total threads in the kernel
//   core_done[N-1:0]     - per-core block-complete flag
//   core_start[N-1:0]    - per-core block-active flag (registered)
//   core_block_id[8N-1:0]     - block index assigned to each core
//   core_thread_count[TW*N-1:0] - threads in each core's assigned block
//   done                 - high while the kernel is complete
module block_dispatcher #(
  parameter int unsigned NUM_CORES         = 2,
  parameter int unsigned THREADS_PER_BLOCK = 4,
  localparam int unsigned TW               = $clog2(THREADS_PER_BLOCK) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [7:0]              thread_count,
  input  logic [NUM_CORES-1:0]    core_done,
  output logic [NUM_CORES-1:0]    core_start,
  output logic [NUM_CORES*8-1:0]  core_block_id,
  output logic [NUM_CORES*TW-1:0] core_thread_count,
  output logic                    done
);

  localparam int unsigned LOG2_TPB = $clog2(THREADS_PER_BLOCK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              tc_q, tc_d;
  logic [8:0]              total_q, total_d;
  logic [8:0]              disp_q, disp_d;
  logic [8:0]              comp_q, comp_d;
  logic [NUM_CORES-1:0]    start_d;
  logic [NUM_CORES*8-1:0]  block_id_d;
  logic [NUM_CORES*TW-1:0] thread_cnt_d;
  logic                    done_d;

  logic [NUM_CORES-1:0]    released;
  logic [8:0]              comp_inc;
  logic                    found;
  logic [15:0]             remaining;
  logic [TW-1:0]           blk_threads;
  logic [8:0]              total_calc;

  // Threads left for the next block to be dispatched, capped at one block
  assign remaining   = 16'(tc_q) - (16'(disp_q) << LOG2_TPB);
  assign blk_threads = (remaining > 16'(THREADS_PER_BLOCK)) ? TW'(THREADS_PER_BLOCK)
                                                            : TW'(remaining);
  // Ceiling division, done at 10 bits so 255 + 127 cannot wrap
  assign total_calc  = 9'((10'(thread_count) + 10'(THREADS_PER_BLOCK - 1)) >> LOG2_TPB);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      tc_q              <= '0;
      total_q           <= '0;
      disp_q            <= '0;
      comp_q            <= '0;
      core_start        <= '0;
      core_block_id     <= '0;
      core_thread_count <= '0;
      done              <= 1'b0;
    end else begin
      state_q           <= state_d;
      tc_q              <= tc_d;
      total_q           <= total_d;
      disp_q            <= disp_d;
      comp_q            <= comp_d;
      core_start        <= start_d;
      core_block_id     <= block_id_d;
      core_thread_count <= thread_cnt_d;
      done              <= done_d;
    end
  end

  // Next-state, dispatch and completion logic
  always_comb begin
    state_d      = state_q;
    tc_d         = tc_q;
    total_d      = total_q;
    disp_d       = disp_q;
    comp_d       = comp_q;
    start_d      = core_start;
    block_id_d   = core_block_id;
    thread_cnt_d = core_thread_count;
    released     = '0;
    comp_inc     = '0;
    found        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          tc_d    = thread_count;
          total_d = total_calc;
          disp_d  = '0;
          comp_d  = '0;
          state_d = (thread_count == 8'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (comp_q == total_q) begin
          state_d = DONE;
        end else begin
          released = core_start & core_done;
          for (int i = 0; i < NUM_CORES; i++) begin
            comp_inc = comp_inc + 9'(released[i]);
          end
          comp_d  = comp_q + comp_inc;
          start_d = core_start & ~released;
          // Idleness uses the registered flag, so a core freed this edge waits a cycle
          if (disp_q < total_q) begin
            for (int i = 0; i < NUM_CORES; i++) begin
              if (!found && !core_start[i]) begin
                found                      = 1'b1;
                start_d[i]                 = 1'b1;
                block_id_d[8*i +: 8]       = 8'(disp_q);
                thread_cnt_d[TW*i +: TW]   = blk_threads;
              end
            end
          end
          if (found) disp_d = disp_q + 9'd1;
        end
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    done_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_block_dispatcher.sv
module tb_block_dispatcher;

  localparam int unsigned NC  = 2;
  localparam int unsigned TPB = 4;
  localparam int unsigned TW  = $clog2(TPB) + 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [7:0]         thread_count;
  logic [NC-1:0]      core_done;
  logic [NC-1:0]      core_start;
  logic [NC*8-1:0]    core_block_id;
  logic [NC*TW-1:0]   core_thread_count;
  logic               done;

  int passed = 0;
  int checks = 0;

  block_dispatcher #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB)) dut (
    .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
    .core_done(core_done), .core_start(core_start), .core_block_id(core_block_id),
    .core_thread_count(core_thread_count), .done(done)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and land on the following falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; thread_count = 8'd0; core_done = '0;
    @(negedge clk);
    step();
    checks++; if (core_start !== 2'b00) $display("FAIL reset_core_start got %b exp 00", core_start); else passed++;
    checks++; if (core_block_id !== 16'h0) $display("FAIL reset_block_id got %h exp 0000", core_block_id); else passed++;
    checks++; if (core_thread_count !== 6'h0) $display("FAIL reset_thread_count got %h exp 00", core_thread_count); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else passed++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic_tc10();
    thread_count = 8'd10; start = 1'b1;
    step();                                    // IDLE -> RUN
    start = 1'b0;
    checks++; if (core_start !== 2'b00) $display("FAIL tc10_launch_start got %b exp 00", core_start); else passed++;
    step();                                    // block 0 -> core0
    checks++; if (core_start !== 2'b01) $display("FAIL tc10_b0_start got %b exp 01", core_start); else passed++;
    checks++; if (core_block_id[7:0] !== 8'd0) $display("FAIL tc10_b0_id got %0d exp 0", core_block_id[7:0]); else passed++;
    checks++; if (core_thread_count[2:0] !== 3'd4) $display("FAIL tc10_b0_cnt got %0d exp 4", core_thread_count[2:0]); else passed++;
    step();                                    // block 1 -> core1
    checks++; if (core_start !== 2'b11) $display("FAIL tc10_b1_start got %b exp 11", core_start); else passed++;
    checks++; if (core_block_id[15:8] !== 8'd1) $display("FAIL tc10_b1_id got %0d exp 1", core_block_id[15:8]); else passed++;
    checks++; if (core_thread_count[5:3] !== 3'd4) $display("FAIL tc10_b1_cnt got %0d exp 4", core_thread_count[5:3]); else passed++;
    core_done = 2'b01;
    step();                                    // core0 released
    core_done = 2'b00;
    checks++; if (core_start !== 2'b10) $display("FAIL tc10_rel0_start got %b exp 10", core_start); else passed++;
    step();                                    // block 2 -> core0
    checks++; if (core_start !== 2'b11) $display("FAIL tc10_b2_start got %b exp 11", core_start); else passed++;
    checks++; if (core_block_id[7:0] !== 8'd2) $display("FAIL tc10_b2_id got %0d exp 2", core_block_id[7:0]); else passed++;
    checks++; if (core_thread_count[2:0] !== 3'd2) $display("FAIL tc10_b2_cnt got %0d exp 2", core_thread_count[2:0]); else passed++;
    checks++; if (core_block_id[15:8] !== 8'd1) $display("FAIL tc10_b1_hold got %0d exp 1", core_block_id[15:8]); else passed++;
    core_done = 2'b11;
    step();                                    // both released, completed = 3
    core_done = 2'b00;
    checks++; if (core_start !== 2'b00) $display("FAIL tc10_relall_start got %b exp 00", core_start); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL tc10_done_early got %b exp 0", done); else passed++;
    step();
    checks++; if (done !== 1'b1) $display("FAIL tc10_done got %b exp 1", done); else passed++;
    step();                                    // start low -> IDLE
    checks++; if (done !== 1'b0) $display("FAIL tc10_idle_done got %b exp 0", done); else passed++;
  endtask

  task automatic test_zero_threads();
    thread_count = 8'd0; start = 1'b1;
    step();
    checks++; if (done !== 1'b1) $display("FAIL tc0_done got %b exp 1", done); else passed++;
    checks++; if (core_start !== 2'b00) $display("FAIL tc0_start got %b exp 00", core_start); else passed++;
    step();
    checks++; if (done !== 1'b1) $display("FAIL tc0_hold_done got %b exp 1", done); else passed++;
    checks++; if (core_start !== 2'b00) $display("FAIL tc0_hold_start got %b exp 00", core_start); else passed++;
    start = 1'b0;
    step();
    checks++; if (done !== 1'b0) $display("FAIL tc0_idle got %b exp 0", done); else passed++;
  endtask

  task automatic test_simultaneous_done();
    thread_count = 8'd8; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    checks++; if (core_start !== 2'b11) $display("FAIL simul_busy got %b exp 11", core_start); else passed++;
    core_done = 2'b11;
    step();
    core_done = 2'b00;
    checks++; if (core_start !== 2'b00) $display("FAIL simul_release got %b exp 00", core_start); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL simul_done_early got %b exp 0", done); else passed++;
    step();
    checks++; if (done !== 1'b1) $display("FAIL simul_done got %b exp 1", done); else passed++;
    step();
  endtask

  task automatic test_done_hold_relaunch();
    // start held high through the whole kernel and afterwards
    thread_count = 8'd4; start = 1'b1;
    step(); step();
    checks++; if (core_start !== 2'b01) $display("FAIL hold_b0_start got %b exp 01", core_start); else passed++;
    thread_count = 8'd200;                     // ignored while running
    core_done = 2'b01;
    step();
    core_done = 2'b00;
    step();
    for (int k = 0; k < 3; k++) begin
      checks++; if (done !== 1'b1) $display("FAIL hold_done cycle %0d got %b exp 1", k, done); else passed++;
      step();
    end
    start = 1'b0;
    step();
    checks++; if (done !== 1'b0) $display("FAIL hold_drop got %b exp 0", done); else passed++;
    thread_count = 8'd4; start = 1'b1;
    step();
    start = 1'b0;
    step();
    checks++; if (core_start !== 2'b01) $display("FAIL relaunch_start got %b exp 01", core_start); else passed++;
    checks++; if (core_block_id[7:0] !== 8'd0) $display("FAIL relaunch_id got %0d exp 0", core_block_id[7:0]); else passed++;
    checks++; if (core_thread_count[2:0] !== 3'd4) $display("FAIL relaunch_cnt got %0d exp 4", core_thread_count[2:0]); else passed++;
    // done from a core that holds no block must be ignored
    core_done = 2'b10;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (core_start !== 2'b01) $display("FAIL idle_done_start cycle %0d got %b exp 01", k, core_start); else passed++;
      checks++; if (done !== 1'b0) $display("FAIL idle_done_done cycle %0d got %b exp 0", k, done); else passed++;
    end
    core_done = 2'b01;
    step();
    core_done = 2'b00;
    step();
    checks++; if (done !== 1'b1) $display("FAIL idle_done_final got %b exp 1", done); else passed++;
    step();
  endtask

  task automatic test_reset_mid_run();
    thread_count = 8'd8; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    checks++; if (core_start !== 2'b11) $display("FAIL rmid_busy got %b exp 11", core_start); else passed++;
    reset = 1'b1; core_done = 2'b01;
    step();
    reset = 1'b0; core_done = 2'b00;
    checks++; if (core_start !== 2'b00) $display("FAIL rmid_start got %b exp 00", core_start); else passed++;
    checks++; if (core_block_id !== 16'h0) $display("FAIL rmid_id got %h exp 0000", core_block_id); else passed++;
    checks++; if (core_thread_count !== 6'h0) $display("FAIL rmid_cnt got %h exp 00", core_thread_count); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL rmid_done got %b exp 0", done); else passed++;
    thread_count = 8'd4; start = 1'b1;         // must launch from IDLE
    step();
    start = 1'b0;
    step();
    checks++; if (core_start !== 2'b01) $display("FAIL rmid_relaunch got %b exp 01", core_start); else passed++;
    core_done = 2'b01;
    step();
    core_done = 2'b00;
    step();
    checks++; if (done !== 1'b1) $display("FAIL rmid_relaunch_done got %b exp 1", done); else passed++;
    step();
  endtask

  // Random kernels against a block-level model of what each core should hold
  task automatic test_random();
    int tc, total_b, next_blk, completed, cyc, cnt_exp;
    bit model_done, ok;
    bit [NC-1:0] busy, rel;
    int exp_id [NC];
    int exp_cnt[NC];

    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < NC; i++) begin exp_id[i] = 0; exp_cnt[i] = 0; end

    for (int k = 0; k < 8; k++) begin
      tc = (k == 0) ? 255 : int'($urandom_range(1, 60));
      total_b = (tc + TPB - 1) / TPB;
      next_blk = 0; completed = 0; busy = '0; model_done = 0; ok = 0;
      thread_count = 8'(tc); start = 1'b1;
      step();
      start = 1'b0;
      thread_count = 8'($urandom);
      for (cyc = 0; cyc < 3000; cyc++) begin
        checks++; if (core_start !== busy) $display("FAIL rnd_start k%0d cyc %0d got %b exp %b", k, cyc, core_start, busy); else passed++;
        for (int i = 0; i < NC; i++) begin
          checks++;
          if (core_block_id[8*i +: 8] !== 8'(exp_id[i]) || core_thread_count[TW*i +: TW] !== TW'(exp_cnt[i]))
            $display("FAIL rnd_block k%0d core %0d got id %0d cnt %0d exp id %0d cnt %0d", k, i,
                     core_block_id[8*i +: 8], core_thread_count[TW*i +: TW], exp_id[i], exp_cnt[i]);
          else passed++;
        end
        checks++; if (done !== model_done) $display("FAIL rnd_done k%0d cyc %0d got %b exp %b", k, cyc, done, model_done); else passed++;
        if (model_done) begin ok = 1; break; end
        core_done = NC'($urandom);
        if (completed == total_b) begin
          model_done = 1;
        end else begin
          rel = busy & core_done;
          for (int i = 0; i < NC; i++) begin
            if (!busy[i] && next_blk < total_b) begin
              cnt_exp = tc - next_blk * TPB;
              exp_id[i] = next_blk;
              exp_cnt[i] = (cnt_exp > TPB) ? TPB : cnt_exp;
              next_blk++;
              busy[i] = 1'b1;
              break;
            end
          end
          for (int i = 0; i < NC; i++) if (rel[i]) begin busy[i] = 1'b0; completed++; end
        end
        step();
      end
      checks++; if (!ok) $display("FAIL rnd_timeout k%0d got no done exp done within 3000 cycles", k); else passed++;
      core_done = '0;
      step();
      checks++; if (done !== 1'b0) $display("FAIL rnd_idle k%0d got %b exp 0", k, done); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_tc10();
    test_zero_threads();
    test_simultaneous_done();
    test_done_hold_relaunch();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
